// File: rtl/sprite_capture_packer.sv
// Captures a 16x16 window from the camera pixel stream, thresholds it to 1 bpp and
// writes it as 32 packed bytes into one slot of the sprite RAM.
module sprite_capture_packer #(
  parameter int unsigned WIN_X0 = 32,
  parameter int unsigned WIN_Y0 = 24,
  parameter int unsigned THRESH = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm_i,
  input  logic [2:0]  slot_i,
  input  logic        frame_start_i,
  input  logic        pix_valid_i,
  input  logic [6:0]  pix_x_i,
  input  logic [5:0]  pix_y_i,
  input  logic [11:0] pix_rgb_i,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [6:0] X_LO = 7'(WIN_X0);
  localparam logic [6:0] X_HI = 7'(WIN_X0 + 15);
  localparam logic [5:0] Y_LO = 6'(WIN_Y0);
  localparam logic [5:0] Y_HI = 6'(WIN_Y0 + 15);
  localparam logic [5:0] TH   = 6'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [7:0]  pack_q, pack_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [5:0]  lum;
  logic        pix_on;
  logic        hit;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        cap_hit;
  logic        last_hit;

  // Pixel datapath: luma threshold and window position
  always_comb begin
    lum      = 6'(pix_rgb_i[11:8]) + 6'({pix_rgb_i[7:4], 1'b0}) + 6'(pix_rgb_i[3:0]);
    pix_on   = (lum >= TH);
    hit      = pix_valid_i && (pix_x_i >= X_LO) && (pix_x_i <= X_HI)
               && (pix_y_i >= Y_LO) && (pix_y_i <= Y_HI);
    col      = 4'(pix_x_i - X_LO);
    row      = 4'(pix_y_i - Y_LO);
    // A frame_start in CAPTURE restarts the frame, so that cycle's pixel is dropped
    cap_hit  = (state_q == S_CAPTURE) && !frame_start_i && hit;
    last_hit = cap_hit && (row == 4'd15) && (col == 4'd15);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm_i) state_d = S_WAIT;
      S_WAIT:    if (frame_start_i) state_d = S_CAPTURE;
      S_CAPTURE: if (last_hit) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    slot_d    = slot_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = (state_q == S_DONE);
    busy_d    = (state_d == S_WAIT) || (state_d == S_CAPTURE);

    if ((state_q == S_IDLE) && arm_i) slot_d = slot_i;
    if (((state_q == S_WAIT) || (state_q == S_CAPTURE)) && frame_start_i) pack_d = 8'h00;

    if (cap_hit) begin
      pack_d[col[2:0]] = pix_on;
      if (col[2:0] == 3'd7) begin
        wr_en_d   = 1'b1;
        wr_addr_d = {slot_q, row, col[3]};
        wr_data_d = {pix_on, pack_q[6:0]};
        pack_d    = 8'h00;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= 3'd0;
      pack_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_sprite_capture_packer.sv
// Directed bench for sprite_capture_packer: raster frames drive a reference packer that
// queues expected RAM writes; each observed write is popped and compared.
module tb_sprite_capture_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i;
  logic [2:0]  slot_i;
  logic        frame_start_i;
  logic        pix_valid_i;
  logic [6:0]  pix_x_i;
  logic [5:0]  pix_y_i;
  logic [11:0] pix_rgb_i;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        busy_o;
  logic        done_o;

  sprite_capture_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm_i        (arm_i),
    .slot_i       (slot_i),
    .frame_start_i(frame_start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_x_i      (pix_x_i),
    .pix_y_i      (pix_y_i),
    .pix_rgb_i    (pix_rgb_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt;
  int done_cnt;
  logic done_due;
  // Entry: {last byte of sprite, addr[7:0], data[7:0]}
  logic [16:0] exp_q[$];
  int          m_st;
  logic [2:0]  m_slot;
  logic [7:0]  m_pack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge and matched against the queue
  task automatic tick();
    logic [16:0] e;
    @(posedge clk);
    #1;
    if (done_o) done_cnt++;
    if (done_o || done_due) check("done_pulse", 32'(done_o), 32'(done_due));
    done_due = 1'b0;
    if (wr_en_o) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_en_unexpected", 32'(wr_en_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e[15:8]));
        check("wr_data", 32'(wr_data_o), 32'(e[7:0]));
        done_due = e[16];
      end
    end
  endtask

  function automatic logic [11:0] color(input int mode, input int x);
    case (mode)
      0:       return 12'hFFF;
      1:       return (x % 2 == 1) ? 12'hFFF : 12'h000;
      2:       return 12'h787;
      3:       return 12'h877;
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive_pixel(input int mode, input int x, input int y);
    logic [11:0] rgb;
    int c, r, lum;
    logic b, last;
    rgb = color(mode, x);
    pix_valid_i = 1'b1;
    pix_x_i     = 7'(x);
    pix_y_i     = 6'(y);
    pix_rgb_i   = rgb;
    if (m_st == 2 && x >= 32 && x <= 47 && y >= 24 && y <= 39) begin
      c   = x - 32;
      r   = y - 24;
      lum = int'(rgb[11:8]) + 2 * int'(rgb[7:4]) + int'(rgb[3:0]);
      b   = (lum >= 30);
      m_pack[c % 8] = b;
      if (c % 8 == 7) begin
        last = (r == 15) && (c == 15);
        exp_q.push_back({last, m_slot, 4'(r), (c >= 8) ? 1'b1 : 1'b0, m_pack});
        m_pack = 8'h00;
        if (last) m_st = 0;
      end
    end
  endtask

  task automatic frame(input int mode, input int n_pix);
    frame_start_i = 1'b1;
    pix_valid_i   = 1'b0;
    if (m_st != 0) begin
      m_st   = 2;
      m_pack = 8'h00;
    end
    tick();
    frame_start_i = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      drive_pixel(mode, i % 80, i / 80);
      tick();
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic arm(input logic [2:0] s);
    arm_i  = 1'b1;
    slot_i = s;
    if (m_st == 0) begin
      m_slot = s;
      m_st   = 1;
    end
    tick();
    arm_i = 1'b0;
  endtask

  task automatic start_test();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic end_test(input string tag, input int exp_wr, input int exp_done);
    for (int i = 0; i < 4; i++) tick();
    check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_dones"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; arm_i = 1'b0; slot_i = 3'd0; frame_start_i = 1'b0;
    pix_valid_i = 1'b0; pix_x_i = 7'd0; pix_y_i = 6'd0; pix_rgb_i = 12'h000;
    done_due = 1'b0; m_st = 0; m_slot = 3'd0; m_pack = 8'h00;
    start_test();

    // 1: reset values, idle, and an unarmed frame produce nothing
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    frame(0, 4800);
    end_test("idle", 0, 0);

    // 2: full white frame into slot 3
    start_test();
    arm(3'd3);
    check("t2_busy_armed", 32'(busy_o), 32'd1);
    frame(0, 4800);
    end_test("white", 32, 1);

    // 3: odd columns lit, slot 0
    start_test();
    arm(3'd0);
    frame(1, 4800);
    end_test("odd", 32, 1);

    // 4: threshold boundary, lum 30 then lum 29
    start_test();
    arm(3'd1);
    frame(2, 4800);
    arm(3'd2);
    frame(3, 4800);
    end_test("thresh", 64, 2);

    // 5: frame restart after window row 5
    start_test();
    arm(3'd6);
    frame(0, 30 * 80);
    check("t5_busy_mid", 32'(busy_o), 32'd1);
    frame(0, 4800);
    end_test("restart", 44, 1);

    // 6: arm while busy is ignored; reset during window row 8
    start_test();
    arm(3'd5);
    arm(3'd2);
    check("t6_busy_wait", 32'(busy_o), 32'd1);
    frame(1, 32 * 80 + 40);
    check("t6_wr_en_before_rst", 32'(wr_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(wr_en_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_st = 0; m_pack = 8'h00; done_due = 1'b0;
    #2 rst_n = 1'b1;
    end_test("abort", 17, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
